scoreboard_register_file: RTL
=============================

# scoreboard_register_file

Parametrised integer register file with a per-register pending-write scoreboard, for the decode stage. Generalises the two-read-port register file in data width, register count, read-port count and outstanding-write depth. Adds same-cycle write-back bypass, saturation back-pressure, a flush and underflow detection. Decode reads operands and reserves destinations; write-back retires them; the CSR unit writes directly.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, register count (power of two, ≥2); AW = log2(NREGS)
- NREAD, 2, number of read ports
- CNT_W, 2, pending-counter width; max outstanding writes per register = 2^CNT_W − 1

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- rd_en_i  in  NREAD  per-port read request
- rd_addr_i  in  NREAD*AW  packed read addresses, port p at [p*AW +: AW]
- rd_data_o  out  NREAD*XLEN  packed read data, port p at [p*XLEN +: XLEN]
- rd_ready_o  out  NREAD  per-port operand valid
- issue_i  in  1  decode reserves destination issue_rd_i
- issue_rd_i  in  AW  destination being reserved
- wb_we_i  in  1  write-back retire
- wb_rd_i  in  AW  write-back destination
- wb_data_i  in  XLEN  write-back data
- csr_we_i  in  1  direct CSR-result write (no scoreboard effect)
- csr_rd_i  in  AW  CSR write destination
- csr_data_i  in  XLEN  CSR write data
- flush_i  in  1  pipeline flush: clear all pending counters
- stall_o  out  1  decode must hold this cycle
- underflow_o  out  1  write-back to a register with counter 0 (error flag)

## Operation
- State: reg[NREGS] (XLEN), cnt[NREGS] (CNT_W). Reset: all reg = 0, all cnt = 0.
- Register 0: reads always return 0 with ready = 1. It is never written. cnt[0] never changes. Issue, write-back and CSR writes to 0 are ignored and never flag underflow.
- Read port p, combinational, with rd_en_i[p] = 1:
  - If cnt[a] = 0: data = reg[a], ready = 1.
  - If cnt[a] = 1 and wb_we_i with wb_rd_i = a this cycle: data = wb_data_i (bypass), ready = 1.
  - Otherwise: data = 0, ready = 0.
  - CSR writes are not bypassed.
- Read port with rd_en_i[p] = 0: data = 0, ready = 0, and the port does not contribute to stall_o.
- Saturation: sat = issue_i && issue_rd_i ≠ 0 && cnt[issue_rd_i] = max && !(wb_we_i && wb_rd_i = issue_rd_i).
- stall_o = (any p: rd_en_i[p] && !rd_ready_o[p]) || sat.
- Counter update, rising edge, per register r ≠ 0:
  - inc = issue_i && issue_rd_i = r && !stall_o.
  - dec = wb_we_i && wb_rd_i = r && cnt[r] ≠ 0.
  - inc only: +1. dec only: −1. Both: unchanged. Neither: unchanged.
- flush_i = 1: all cnt ← 0 at the edge. Flush overrides inc and dec. Data writes in the same cycle still occur.
- Data write, rising edge: if wb_we_i, reg[wb_rd_i] ← wb_data_i. If csr_we_i, reg[csr_rd_i] ← csr_data_i. When both target the same register, CSR wins.
- underflow_o = wb_we_i && wb_rd_i ≠ 0 && cnt[wb_rd_i] = 0 && !flush_i. On underflow the data is still written and the counter stays 0.

## Timing
- Reads, ready and stall_o are combinational, with zero latency from inputs and current state.
- Write-back data is visible through reg on the cycle after the edge, or the same cycle via bypass when it is the last pending write.
- A reservation takes effect at the next edge. A same-cycle read of the register being issued sees the pre-issue counter.
- A stalled issue is not recorded; decode re-presents it the next cycle.
- Asynchronous reset clears state immediately, mid-operation. While rst_i = 0: ready = 1 only for ports reading with cnt = 0, and all data reads 0.

## Test plan
- Reset, then read x5 and x31 -> ready = 1, data = 0, stall_o = 0. Write-back x5 = 0xDEADBEEF with cnt 0 -> underflow_o = 1, and x5 reads 0xDEADBEEF next cycle.
- Issue x7, then read x7 -> stall_o = 1. Write-back x7 = 0x12345678 in the same cycle as the read -> bypass data 0x12345678, ready = 1, stall_o = 0. cnt[7] = 0 after the edge.
- Issue x3 three times (CNT_W = 2), then a fourth issue -> stall_o = 1 and cnt stays 3. Fourth issue with a simultaneous write-back to x3 -> no stall, cnt stays 3.
- Simultaneous issue and write-back to x9 with cnt[9] = 1 -> cnt remains 1, data updated, and a read of x9 next cycle -> ready = 0.
- Pending x4 = 2, x6 = 1, then flush_i -> both cnt = 0 next cycle and reads ready. Same-cycle CSR and write-back to x8 (0xAAAA / 0x5555) -> x8 = 0xAAAA.
- Writes and issue to x0, and rst_i asserted low between edges mid-sequence -> x0 reads 0, all counters clear asynchronously, stall_o drops.

Source files
------------

// File: rtl/scoreboard_register_file.sv
// Integer register file for the decode stage with a per-register
// pending-write counter. Decode reads operands and reserves destinations,
// write-back retires reservations, and the CSR unit writes data directly.
// Reads, ready, stall and underflow are combinational; state changes on
// the rising clock edge and clears asynchronously on an active-low reset.
module scoreboard_register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int CNT_W = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREAD-1:0]      rd_en_i,
  input  logic [NREAD*AW-1:0]   rd_addr_i,
  output logic [NREAD*XLEN-1:0] rd_data_o,
  output logic [NREAD-1:0]      rd_ready_o,
  input  logic                  issue_i,
  input  logic [AW-1:0]         issue_rd_i,
  input  logic                  wb_we_i,
  input  logic [AW-1:0]         wb_rd_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic                  csr_we_i,
  input  logic [AW-1:0]         csr_rd_i,
  input  logic [XLEN-1:0]       csr_data_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  underflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Architectural state. Entry 0 of both arrays stays zero forever.
  logic [XLEN-1:0]  regs [NREGS];
  logic [CNT_W-1:0] cnt  [NREGS];

  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] dec;
  logic [NREAD-1:0] port_block;
  logic             sat;

  // Read ports: committed value when nothing is pending, the write-back
  // value when it retires the final pending write this cycle, otherwise
  // not ready. CSR writes are deliberately not forwarded.
  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            ready;

      assign addr = rd_addr_i[gi*AW +: AW];

      // Resolve one port's data and ready from state plus the bypass path
      always_comb begin
        data  = '0;
        ready = 1'b0;
        if (rd_en_i[gi]) begin
          if (addr == '0) begin
            ready = 1'b1;
          end else if (cnt[addr] == '0) begin
            data  = regs[addr];
            ready = 1'b1;
          end else if (cnt[addr] == CNT_ONE && wb_we_i && wb_rd_i == addr) begin
            data  = wb_data_i;
            ready = 1'b1;
          end
        end
      end

      assign rd_data_o[gi*XLEN +: XLEN] = data;
      assign rd_ready_o[gi]             = ready;
    end
  endgenerate

  // A reservation cannot be taken when the counter is full, unless a
  // write-back to the same register frees a slot in the same cycle.
  assign sat = issue_i && (issue_rd_i != '0) && (cnt[issue_rd_i] == CNT_MAX) &&
               !(wb_we_i && wb_rd_i == issue_rd_i);

  assign port_block = rd_en_i & ~rd_ready_o;
  assign stall_o    = (|port_block) || sat;

  // Write-back with nothing outstanding is an error; a flush legitimately
  // discards reservations, so in-flight results arriving then are not flagged.
  assign underflow_o = wb_we_i && (wb_rd_i != '0) && (cnt[wb_rd_i] == '0) && !flush_i;

  // Per-register increment / decrement requests; register 0 never counts.
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_cnt_req
      if (gi == 0) begin : g_zero
        assign inc[gi] = 1'b0;
        assign dec[gi] = 1'b0;
      end else begin : g_live
        assign inc[gi] = issue_i && (issue_rd_i == AW'(gi)) && !stall_o;
        assign dec[gi] = wb_we_i && (wb_rd_i == AW'(gi)) && (cnt[gi] != '0);
      end
    end
  endgenerate

  // Pending counters: flush clears everything, otherwise +1 / -1 / hold
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (flush_i) begin
          cnt[r] <= '0;
        end else if (inc[r] && !dec[r]) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec[r] && !inc[r]) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  // Data writes: write-back then CSR, so CSR wins on a shared destination
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      if (wb_we_i && wb_rd_i != '0) begin
        regs[wb_rd_i] <= wb_data_i;
      end
      if (csr_we_i && csr_rd_i != '0) begin
        regs[csr_rd_i] <= csr_data_i;
      end
    end
  end

endmodule
